// File: rtl/multiciclo_mem_unit_if.sv
// Request/response bus between the multicycle control FSM and the memory unit.
// The requester drives the i* signals, the memory unit drives the o* signals.
interface multiciclo_mem_unit_if;
    logic        iReq;
    logic        iWe;
    logic [31:0] iAddr;
    logic [31:0] iWData;
    logic [2:0]  iFunct3;
    logic [31:0] oRData;
    logic        oReady;
    logic        oBusy;
    logic        oMisaligned;
    logic        oBankErr;

    modport master (
        output iReq, iWe, iAddr, iWData, iFunct3,
        input  oRData, oReady, oBusy, oMisaligned, oBankErr
    );

    modport slave (
        input  iReq, iWe, iAddr, iWData, iFunct3,
        output oRData, oReady, oBusy, oMisaligned, oBankErr
    );
endinterface

// File: rtl/multiciclo_mem_unit.sv
// Banked text/data memory for the multicycle core: byte/half/word access with
// sign/zero extension, programmable wait states and a req/ready handshake.
//
//  state     | meaning
//  ----------+--------------------------------------------------------------
//  ST_IDLE   | waiting for iReq; request fields and error flags are latched
//  ST_WAIT   | wait-state down-counter running, leaves at terminal count 0
//  ST_ACCESS | array read or byte-enabled write of the latched word
//  ST_RESP   | oReady pulse; load data / error flags presented
module multiciclo_mem_unit #(
    parameter int ADDR_BITS    = 10,
    parameter int NUM_BANKS    = 2,
    parameter int BANK_SEL_LSB = 28,
    parameter int WAIT_STATES  = 1
) (
    input  logic                   clockCPU,
    input  logic                   reset,
    multiciclo_mem_unit_if.slave   bus
);

    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} stateType;

    stateType              state, nextState;
    logic [3:0]            waitCnt, nextWaitCnt;
    logic                  reqWe;
    logic [2:0]            reqFunct3;
    logic [1:0]            reqByte;
    logic [ADDR_BITS-1:0]  reqWord;
    logic [BANK_W-1:0]     reqBank;
    logic [31:0]           reqWData;
    logic                  errMis, errBank;
    logic                  inMis, inBankErr, reqErr;
    logic [BANK_W-1:0]     inBank;
    logic [31:0]           rData, memWord, loadValue, laneData;
    logic [3:0]            byteEn;

    logic [31:0] mem [NUM_BANKS][2**ADDR_BITS];

    // The select field only indexes the array; the error check looks at every
    // address bit from BANK_SEL_LSB upward so aliases above the field are caught.
    generate
        if (NUM_BANKS > 1) begin : gBankSel
            assign inBank    = bus.iAddr[BANK_SEL_LSB +: BANK_W];
            assign inBankErr = (bus.iAddr >> BANK_SEL_LSB) >= 32'(NUM_BANKS);
        end else begin : gOneBank
            assign inBank    = '0;
            assign inBankErr = 1'b0;
        end
    endgenerate

    // Alignment check on the incoming request; stores with funct3[2] set are illegal.
    always_comb begin
        inMis = 1'b0;
        case (bus.iFunct3[1:0])
            2'b00:   inMis = 1'b0;
            2'b01:   inMis = bus.iAddr[0];
            default: inMis = |bus.iAddr[1:0];
        endcase
        if (bus.iWe && bus.iFunct3[2]) inMis = 1'b1;
    end

    assign reqErr = inMis | inBankErr;

    // Next-state and wait-counter logic.
    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        case (state)
            ST_IDLE: begin
                if (bus.iReq) begin
                    if (reqErr) begin
                        nextState = ST_RESP;
                    end else if (WAIT_STATES > 0) begin
                        nextState   = ST_WAIT;
                        nextWaitCnt = WAIT_INIT;
                    end else begin
                        nextState = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (waitCnt == 4'd0) nextState = ST_ACCESS;
                else                 nextWaitCnt = waitCnt - 4'd1;
            end
            ST_ACCESS: nextState = ST_RESP;
            ST_RESP:   nextState = ST_IDLE;
            default:   nextState = ST_IDLE;
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge clockCPU or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            waitCnt <= 4'd0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
        end
    end

    // Capture the request fields and its error flags when it is accepted.
    always_ff @(posedge clockCPU or posedge reset) begin
        if (reset) begin
            reqWe     <= 1'b0;
            reqFunct3 <= 3'b000;
            reqByte   <= 2'b00;
            reqWord   <= '0;
            reqBank   <= '0;
            reqWData  <= 32'h0;
            errMis    <= 1'b0;
            errBank   <= 1'b0;
        end else if (state == ST_IDLE && bus.iReq) begin
            reqWe     <= bus.iWe;
            reqFunct3 <= bus.iFunct3;
            reqByte   <= bus.iAddr[1:0];
            reqWord   <= bus.iAddr[ADDR_BITS+1:2];
            reqBank   <= inBank;
            reqWData  <= bus.iWData;
            errMis    <= inMis;
            errBank   <= inBankErr;
        end
    end

    assign memWord  = mem[reqBank][reqWord];
    assign laneData = reqWData << {reqByte, 3'b000};

    // Byte-enable for the store lanes.
    always_comb begin
        byteEn = 4'b1111;
        case (reqFunct3[1:0])
            2'b00:   byteEn = 4'b0001 << reqByte;
            2'b01:   byteEn = 4'b0011 << {reqByte[1], 1'b0};
            default: byteEn = 4'b1111;
        endcase
    end

    // Lane extraction and sign/zero extension of the loaded word.
    always_comb begin
        logic [31:0] lane;
        lane      = memWord >> {reqByte, 3'b000};
        loadValue = memWord;
        case (reqFunct3)
            3'b000:  loadValue = {{24{lane[7]}}, lane[7:0]};
            3'b001:  loadValue = {{16{lane[15]}}, lane[15:0]};
            3'b100:  loadValue = {24'h0, lane[7:0]};
            3'b101:  loadValue = {16'h0, lane[15:0]};
            default: loadValue = memWord;
        endcase
    end

    // Array write; contents survive reset.
    always_ff @(posedge clockCPU) begin
        if (state == ST_ACCESS && reqWe) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) mem[reqBank][reqWord][8*i +: 8] <= laneData[8*i +: 8];
            end
        end
    end

    // Response data: cleared on error, loaded at the end of ACCESS, otherwise held.
    always_ff @(posedge clockCPU or posedge reset) begin
        if (reset) begin
            rData <= 32'h0;
        end else if (state == ST_IDLE && bus.iReq && reqErr) begin
            rData <= 32'h0;
        end else if (state == ST_ACCESS && !reqWe) begin
            rData <= loadValue;
        end
    end

    assign bus.oRData      = rData;
    assign bus.oReady      = (state == ST_RESP);
    assign bus.oBusy       = (state != ST_IDLE);
    assign bus.oMisaligned = (state == ST_RESP) && errMis;
    assign bus.oBankErr    = (state == ST_RESP) && errBank;

endmodule

// File: tb/tb_multiciclo_mem_unit.sv
// Self-checking bench for multiciclo_mem_unit: directed scenarios plus a
// randomized run against a byte-addressed reference model.
module tb_multiciclo_mem_unit;

    logic clockCPU = 1'b0;
    logic reset    = 1'b1;
    always #5 clockCPU = ~clockCPU;

    multiciclo_mem_unit_if bus1();
    multiciclo_mem_unit_if bus0();

    multiciclo_mem_unit #(.ADDR_BITS(10), .NUM_BANKS(2), .BANK_SEL_LSB(28), .WAIT_STATES(1))
        dut1 (.clockCPU(clockCPU), .reset(reset), .bus(bus1.slave));
    multiciclo_mem_unit #(.ADDR_BITS(10), .NUM_BANKS(2), .BANK_SEL_LSB(28), .WAIT_STATES(0))
        dut0 (.clockCPU(clockCPU), .reset(reset), .bus(bus0.slave));

    int checks = 0;
    int errors = 0;

    // Reference model state for dut1: bytes per bank, and the last response data.
    logic [7:0]  refMem [2][4096];
    logic [31:0] refLastRd = 32'h0;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3);
        if (sel) begin
            bus1.iReq = req; bus1.iWe = we; bus1.iAddr = addr; bus1.iWData = wd; bus1.iFunct3 = f3;
        end else begin
            bus0.iReq = req; bus0.iWe = we; bus0.iAddr = addr; bus0.iWData = wd; bus0.iFunct3 = f3;
        end
    endtask

    // Behavioural model: byte-addressed memory, access size from funct3, error rules.
    function automatic void refOp(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [2:0] f3, output logic [31:0] expRd,
                                  output logic expMis, output logic expBe, output int expLat);
        int sz;
        int bank;
        int off;
        logic [31:0] val;
        sz     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        expMis = ((addr % sz) != 0) || (we && f3[2]);
        expBe  = (addr >> 28) >= 2;
        if (expMis || expBe) begin
            expLat    = 1;
            refLastRd = 32'h0;
        end else begin
            expLat = 3;
            bank   = int'(addr[28]);
            off    = int'(addr[11:0]);
            if (we) begin
                for (int i = 0; i < sz; i++) refMem[bank][off + i] = wd[8*i +: 8];
            end else begin
                val = 32'h0;
                for (int i = 0; i < sz; i++) val = val | (32'(refMem[bank][off + i]) << (8 * i));
                if (!f3[2] && sz == 1 && val[7])  val = val | 32'hFFFF_FF00;
                if (!f3[2] && sz == 2 && val[15]) val = val | 32'hFFFF_0000;
                refLastRd = val;
            end
        end
        expRd = refLastRd;
    endfunction

    // One handshake: request at a falling edge, count cycles until oReady.
    task automatic access(input bit sel, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] f3, output logic [31:0] rd, output logic mis,
                          output logic be, output int lat, output int leak);
        logic rdy, bsy, m, b;
        logic [31:0] d;
        lat = -1; leak = 0; rd = 32'h0; mis = 1'b0; be = 1'b0;
        @(negedge clockCPU);
        drive(sel, 1'b1, we, addr, wd, f3);
        @(posedge clockCPU);
        #1;
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            @(negedge clockCPU);
            if (sel) begin
                rdy = bus1.oReady; bsy = bus1.oBusy; m = bus1.oMisaligned; b = bus1.oBankErr; d = bus1.oRData;
            end else begin
                rdy = bus0.oReady; bsy = bus0.oBusy; m = bus0.oMisaligned; b = bus0.oBankErr; d = bus0.oRData;
            end
            if (!bsy) leak++;
            if (rdy) begin
                lat = n; rd = d; mis = m; be = b;
            end else if (m || b) begin
                leak++;
            end
        end
    endtask

    task automatic runCheck(input string tag, input bit sel, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [2:0] f3, input logic [31:0] expRd,
                            input logic expMis, input logic expBe, input int expLat);
        logic [31:0] rd;
        logic mis, be;
        int lat, leak;
        access(sel, we, addr, wd, f3, rd, mis, be, lat, leak);
        checkValue({tag, ".lat"},  32'(lat), 32'(expLat));
        checkValue({tag, ".mis"},  32'(mis), 32'(expMis));
        checkValue({tag, ".bank"}, 32'(be),  32'(expBe));
        checkValue({tag, ".data"}, rd, expRd);
        checkValue({tag, ".hs"},   32'(leak), 32'd0);
    endtask

    // Model-driven operation on dut1.
    task automatic modelOp(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [2:0] f3);
        logic [31:0] eRd;
        logic eMis, eBe;
        int eLat;
        refOp(we, addr, wd, f3, eRd, eMis, eBe, eLat);
        runCheck(tag, 1'b1, we, addr, wd, f3, eRd, eMis, eBe, eLat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [2:0] ldF3 [10];
        logic [2:0] stF3 [10];
        int readyAt [$];
        int seen;
        logic [31:0] eRd;
        logic eMis, eBe;
        int eLat;

        ldF3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b001, 3'b010, 3'b011, 3'b110};
        stF3 = '{3'b000, 3'b001, 3'b010, 3'b000, 3'b001, 3'b010, 3'b100, 3'b000, 3'b001, 3'b010};

        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        repeat (3) @(negedge clockCPU);
        checkValue("rst.ready", 32'(bus1.oReady), 32'd0);
        checkValue("rst.busy",  32'(bus1.oBusy),  32'd0);
        checkValue("rst.flags", 32'({bus1.oMisaligned, bus1.oBankErr}), 32'd0);
        checkValue("rst.data",  bus1.oRData, 32'h0);
        checkValue("rst.data0", bus0.oRData, 32'h0);
        reset = 1'b0;

        // Word store/load with one wait state.
        modelOp("t1.sw", 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 3'b010);
        runCheck("t1.lw", 1'b1, 1'b0, 32'h1000_0004, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0, 1'b0, 3);
        refOp(1'b0, 32'h1000_0004, 32'h0, 3'b010, eRd, eMis, eBe, eLat);

        // Byte store, signed/unsigned byte loads, word readback.
        modelOp("t2.sb", 1'b1, 32'h1000_0006, 32'h0000_0080, 3'b000);
        runCheck("t2.lb",  1'b1, 1'b0, 32'h1000_0006, 32'h0, 3'b000, 32'hFFFF_FF80, 1'b0, 1'b0, 3);
        runCheck("t2.lbu", 1'b1, 1'b0, 32'h1000_0006, 32'h0, 3'b100, 32'h0000_0080, 1'b0, 1'b0, 3);
        runCheck("t2.lw",  1'b1, 1'b0, 32'h1000_0004, 32'h0, 3'b010, 32'hDE80_BEEF, 1'b0, 1'b0, 3);
        refOp(1'b0, 32'h1000_0004, 32'h0, 3'b010, eRd, eMis, eBe, eLat);

        // Misaligned halfword, then memory unchanged.
        runCheck("t3.lh", 1'b1, 1'b0, 32'h1000_0003, 32'h0, 3'b001, 32'h0, 1'b1, 1'b0, 1);
        refOp(1'b0, 32'h1000_0003, 32'h0, 3'b001, eRd, eMis, eBe, eLat);
        modelOp("t3.lw", 1'b0, 32'h1000_0004, 32'h0, 3'b010);

        // Unmapped bank, and zero-wait-state latency.
        runCheck("t4.bank", 1'b1, 1'b0, 32'h2000_0000, 32'h0, 3'b010, 32'h0, 1'b0, 1'b1, 1);
        refOp(1'b0, 32'h2000_0000, 32'h0, 3'b010, eRd, eMis, eBe, eLat);
        runCheck("t4.sw0", 1'b0, 1'b1, 32'h0000_0000, 32'h1357_9BDF, 3'b010, 32'h0, 1'b0, 1'b0, 2);
        runCheck("t4.lw0", 1'b0, 1'b0, 32'h0000_0000, 32'h0, 3'b010, 32'h1357_9BDF, 1'b0, 1'b0, 2);

        // Reset during the wait state of a store.
        modelOp("t5.pre", 1'b1, 32'h1000_0008, 32'hCAFE_F00D, 3'b010);
        modelOp("t5.prl", 1'b0, 32'h1000_0004, 32'h0, 3'b010);
        @(negedge clockCPU);
        drive(1'b1, 1'b1, 1'b1, 32'h1000_0008, 32'h1234_5678, 3'b010);
        @(posedge clockCPU);
        #1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        checkValue("t5.busyWait", 32'(bus1.oBusy), 32'd1);
        #2 reset = 1'b1;
        #1;
        checkValue("t5.rstBusy",  32'(bus1.oBusy),  32'd0);
        checkValue("t5.rstReady", 32'(bus1.oReady), 32'd0);
        checkValue("t5.rstData",  bus1.oRData, 32'h0);
        checkValue("t5.rstFlags", 32'({bus1.oMisaligned, bus1.oBankErr}), 32'd0);
        refLastRd = 32'h0;
        repeat (2) @(negedge clockCPU);
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clockCPU);
            if (bus1.oReady) seen++;
        end
        checkValue("t5.noReady", 32'(seen), 32'd0);
        runCheck("t5.lw", 1'b1, 1'b0, 32'h1000_0008, 32'h0, 3'b010, 32'hCAFE_F00D, 1'b0, 1'b0, 3);
        refOp(1'b0, 32'h1000_0008, 32'h0, 3'b010, eRd, eMis, eBe, eLat);

        // Continuous request: one access every WAIT_STATES+3 cycles.
        refOp(1'b0, 32'h1000_0004, 32'h0, 3'b010, eRd, eMis, eBe, eLat);
        @(negedge clockCPU);
        drive(1'b1, 1'b1, 1'b0, 32'h1000_0004, 32'h0, 3'b010);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clockCPU);
            if (bus1.oReady) begin
                readyAt.push_back(n);
                checkValue("t6.data", bus1.oRData, eRd);
            end
            if (n == 12) drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        end
        checkValue("t6.count", 32'(readyAt.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkValue("t6.cycle", (i < readyAt.size()) ? 32'(readyAt[i]) : 32'hFFFF_FFFF, 32'(3 + 4 * i));
        end

        // Fill a small window of both banks, then random traffic.
        for (int w = 0; w < 16; w++) begin
            modelOp("init0", 1'b1, 32'(4 * w), $urandom, 3'b010);
            modelOp("init1", 1'b1, 32'h1000_0000 | 32'(4 * w), $urandom, 3'b010);
        end
        for (int k = 0; k < 60; k++) begin
            logic we;
            logic [2:0] f3;
            int field;
            int pick;
            logic [31:0] addr;
            we    = 1'($urandom_range(0, 1));
            pick  = $urandom_range(0, 9);
            f3    = we ? stF3[pick] : ldF3[pick];
            pick  = $urandom_range(0, 9);
            field = (pick < 4) ? 0 : (pick < 8) ? 1 : pick - 6;
            addr  = (32'(field) << 28) | 32'($urandom_range(0, 63));
            modelOp("rnd", we, addr, $urandom, f3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
